// File: rtl/dcache_pkg.sv
// Shared types for the MEM-stage data cache.
// State encoding and address-field helpers.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Byte-offset bits below the word field of an address.
    localparam int BYTE_BITS = 2;

    function automatic int tag_width(int aw, int ib, int ob);
        return aw - ib - ob - BYTE_BITS;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Asynchronous read, synchronous word write and line-valid update.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int TAG_W      = 26,
    parameter int DATA_W     = 32,
    parameter int INDEX_BITS = 4,
    parameter int OFFS_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [OFFS_BITS-1:0]  rd_word,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  we,
    input  logic [OFFS_BITS-1:0]  wr_word,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  fill,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic                  inv
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFS_BITS;

    logic [DATA_W-1:0] data_q [LINES][WORDS];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_data  = data_q[index][rd_word];

    // Valid bits: cleared by reset, set when a refill completes, cleared on refill entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[index] <= 1'b1;
        end else if (inv) begin
            valid_q[index] <= 1'b0;
        end
    end

    // Data words and tags are not reset; validity guards them.
    always_ff @(posedge clk) begin
        if (we) begin
            data_q[index][wr_word] <= wr_data;
        end
        if (fill) begin
            tag_q[index] <= fill_tag;
        end
    end

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, write-through, no-write-allocate.
// Refills a line one word per memory handshake and stalls the pipe via hit.
module mem_stage_dcache
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_BITS = 4,
    parameter int OFFS_BITS  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] readData,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS, OFFS_BITS);
    localparam int LO    = OFFS_BITS + BYTE_BITS;

    state_t                state_q, state_n;
    logic [OFFS_BITS-1:0]  cnt_q, cnt_n;
    logic                  done_q, done_n;
    logic                  req_n, we_n;
    logic [ADDR_W-1:0]     addr_n;
    logic [DATA_W-1:0]     wdata_n;

    logic [OFFS_BITS-1:0]  word;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            unused_bits;

    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid;
    logic                  lookup;
    logic                  arr_we, arr_fill, arr_inv;
    logic [OFFS_BITS-1:0]  arr_word;
    logic [DATA_W-1:0]     arr_data;

    assign word        = addr[LO-1:BYTE_BITS];
    assign index       = addr[LO +: INDEX_BITS];
    assign tag         = addr[ADDR_W-1 -: TAG_W];
    assign unused_bits = addr[1:0];
    assign lookup      = rd_valid && (rd_tag == tag);

    dcache_array #(
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W),
        .INDEX_BITS (INDEX_BITS),
        .OFFS_BITS  (OFFS_BITS)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (index),
        .rd_word  (word),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_data  (readData),
        .we       (arr_we),
        .wr_word  (arr_word),
        .wr_data  (arr_data),
        .fill     (arr_fill),
        .fill_tag (tag),
        .inv      (arr_inv)
    );

    // A held store reports completion once, in the cycle after its ack.
    assign hit = (state_q == IDLE) &&
                 (memWrite ? done_q : (!memRead || lookup));

    // State and memory-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            done_q    <= done_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
        end
    end

    // Next-state, memory-port and array-write decode.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        done_n   = 1'b0;
        req_n    = mem_req;
        we_n     = mem_we;
        addr_n   = mem_addr;
        wdata_n  = mem_wdata;
        arr_we   = 1'b0;
        arr_fill = 1'b0;
        arr_inv  = 1'b0;
        arr_word = word;
        arr_data = wdata;
        unique case (state_q)
            IDLE: begin
                if (memWrite && !done_q) begin
                    state_n = WRITE;
                    req_n   = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = {addr[ADDR_W-1:BYTE_BITS], {BYTE_BITS{1'b0}}};
                    wdata_n = wdata;
                end else if (memRead && !memWrite && !lookup) begin
                    state_n = REFILL;
                    req_n   = 1'b1;
                    we_n    = 1'b0;
                    addr_n  = {addr[ADDR_W-1:LO], {LO{1'b0}}};
                    cnt_n   = '0;
                    arr_inv = 1'b1;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    arr_we   = 1'b1;
                    arr_word = cnt_q;
                    arr_data = mem_rdata;
                    cnt_n    = cnt_q + OFFS_BITS'(1);
                    if (cnt_q == '1) begin
                        arr_fill = 1'b1;
                        req_n    = 1'b0;
                        state_n  = IDLE;
                    end else begin
                        addr_n = mem_addr + ADDR_W'(4);
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    arr_we  = lookup;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Scoreboard bench for mem_stage_dcache.
// Memory transactions and load results are queued by stimulus, checked by monitors.
module tb_mem_stage_dcache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead, memWrite;
    logic [31:0] addr, wdata, readData;
    logic        hit, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        mem_exp[$];
    logic [31:0] load_exp[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_cyc = -10;
    int          ack_cnt = 0;

    mem_stage_dcache dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .addr      (addr),
        .wdata     (wdata),
        .readData  (readData),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model and transaction monitor: ack two cycles into each request.
    initial begin
        int dly;
        txn_t e;
        dly = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || mem_ack) begin
                mem_ack = 1'b0;
                dly = 0;
            end else if (mem_req) begin
                dly++;
                if (dly == 2) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_addr ^ 32'hA5A5_0000;
                    ack_cyc = cyc;
                    ack_cnt++;
                    checks++;
                    if (mem_exp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_txn: got we=%b addr=%h expected none",
                                 mem_we, mem_addr);
                    end else begin
                        e = mem_exp.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.a ||
                            (e.we && mem_wdata !== e.d)) begin
                            errors++;
                            $display("FAIL txn: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                                     mem_we, mem_addr, mem_wdata, e.we, e.a, e.d);
                        end
                    end
                end
            end
        end
    end

    // Load monitor: compare readData whenever a load completes.
    initial forever begin
        @(negedge clk);
        if (rst_n && hit && memRead && !memWrite) begin
            if (load_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got %h expected none", readData);
            end else begin
                chk("readData", readData, load_exp.pop_front());
            end
        end
    end

    task automatic wait_hit(output int waited);
        waited = 0;
        @(negedge clk);
        while (!hit && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        chk("hit_timeout", {31'd0, hit}, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp,
                           input int nwords);
        int waited;
        for (int i = 0; i < nwords; i++)
            mem_exp.push_back('{1'b0, (a & ~32'hF) + 32'(4 * i), 32'h0});
        load_exp.push_back(exp);
        memRead = 1'b1;
        memWrite = 1'b0;
        addr = a;
        wait_hit(waited);
        if (!hit) load_exp.delete();
        if (nwords == 0) begin
            chk("warm_latency", 32'(waited), 32'd0);
            chk("warm_no_req", {31'd0, mem_req}, 32'd0);
        end else begin
            chk("refill_latency", 32'(cyc), 32'(ack_cyc + 1));
        end
        @(posedge clk);
        #1;
        memRead = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int waited;
        mem_exp.push_back('{1'b1, a & ~32'h3, d});
        memRead = 1'b0;
        memWrite = 1'b1;
        addr = a;
        wdata = d;
        wait_hit(waited);
        chk("store_latency", 32'(cyc), 32'(ack_cyc + 1));
        @(posedge clk);
        #1;
        memWrite = 1'b0;
    endtask

    initial begin
        int waited;
        int base;
        rst_n = 1'b0;
        memRead = 1'b0;
        memWrite = 1'b0;
        addr = '0;
        wdata = '0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_hit_idle", {31'd0, hit}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_load(32'h40, 32'hA5A5_0040, 4);
        do_load(32'h48, 32'hA5A5_0048, 0);

        do_store(32'h44, 32'hDEAD_BEEF);
        do_load(32'h44, 32'hDEAD_BEEF, 0);

        do_store(32'h300, 32'h1234_5678);
        do_load(32'h300, 32'hA5A5_0300, 4);

        do_load(32'h140, 32'hA5A5_0140, 4);
        do_load(32'h40, 32'hA5A5_0040, 4);

        // Abort a refill with reset after its second word.
        mem_exp.push_back('{1'b0, 32'h140, 32'h0});
        mem_exp.push_back('{1'b0, 32'h144, 32'h0});
        base = ack_cnt;
        memRead = 1'b1;
        addr = 32'h140;
        waited = 0;
        while (ack_cnt < base + 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_acks", 32'(ack_cnt - base), 32'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        memRead = 1'b0;
        #1;
        chk("abort_hit_idle", {31'd0, hit}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_load(32'h40, 32'hA5A5_0040, 4);
        do_load(32'h4C, 32'hA5A5_004C, 0);

        repeat (4) @(posedge clk);
        chk("mem_queue_empty", 32'(mem_exp.size()), 32'd0);
        chk("load_queue_empty", 32'(load_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
